cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 FIFO_DEPTH, 2, entries per source queue; power of two, at least 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous pipeline flush (mispredict recovery).
REQ-005 alu_valid  input  1  ALU result offered.
REQ-006 alu_rob_id  input  `ROB_ID_WIDTH  destination ROB tag of ALU result.
REQ-007 alu_value  input  32  ALU result value.
REQ-008 alu_target  input  32  resolved next PC (branch/jump); don't-care otherwise.
REQ-009 alu_mispredict  input  1  resolved target differs from predicted target.
REQ-010 alu_ready  output  1  ALU queue can accept this cycle.
REQ-011 lsb_valid  input  1  LSB result offered (load data or store completion).
REQ-012 lsb_rob_id  input  `ROB_ID_WIDTH  destination ROB tag of LSB result.
REQ-013 lsb_value  input  32  LSB result value.
REQ-014 lsb_ready  output  1  LSB queue can accept this cycle.
REQ-015 cdb_valid  output  1  broadcast valid; registered.
REQ-016 cdb_rob_id  output  `ROB_ID_WIDTH  broadcast tag; registered.
REQ-017 cdb_value  output  32  broadcast value; registered.
REQ-018 cdb_target  output  32  broadcast target; 0 for LSB source; registered.
REQ-019 cdb_mispredict  output  1  broadcast mispredict flag; 0 for LSB source; registered.
REQ-020 cdb_src  output  1  0 = ALU, 1 = LSB; registered.

Function
REQ-021 The block SHALL hold one circular FIFO of FIFO_DEPTH entries per source (ALU entry: tag, value, target, mispredict; LSB entry: tag, value).
REQ-022 alu_ready/lsb_ready SHALL equal (source count < FIFO_DEPTH), derived from state only; no dependence on valid or same-cycle pop.
REQ-023 Push SHALL occur at the edge where valid && ready; valid while ready=0 is ignored, and the producer holds the result.
REQ-024 Each cycle with at least one non-empty FIFO, exactly one head SHALL be popped and loaded into the CDB registers.
REQ-025 Arbitration: single non-empty source wins; both non-empty -> the source not granted last time wins (round-robin flag rr_last).
REQ-026 rr_last SHALL update only on a grant made while both queues were non-empty.
REQ-027 With both FIFOs empty, cdb_valid SHALL be 0 next cycle; other cdb_* fields hold their previous values.
REQ-028 Latency: result pushed at edge of cycle N SHALL appear on cdb_* in cycle N+2 at the earliest; there is no bypass around the FIFO.
REQ-029 Push and pop on the same source in one cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-030 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
REQ-031 Peak throughput SHALL be one broadcast per cycle; sustained alternating grants when both queues are backlogged.
REQ-032 flush SHALL, at that edge, empty both FIFOs, drop same-cycle pushes, clear cdb_valid and leave rr_last unchanged.
REQ-033 A flush with rst high is subsumed by reset.

Reset
REQ-034 On rst: FIFO pointers and counts 0, rr_last = 1 (ALU preferred first), cdb_valid/cdb_rob_id/cdb_value/cdb_target/cdb_mispredict/cdb_src = 0.
REQ-035 alu_ready and lsb_ready SHALL read 1 in the first cycle after reset deasserts; inputs during rst are dropped.

Verification
REQ-036 Single ALU push (tag 3, value 0x55, target 0x100, mispredict 1) in cycle 1 -> cycle 3: cdb_valid=1, src=0, tag 3, value 0x55, target 0x100, mispredict 1; cycle 4: cdb_valid=0.
REQ-037 ALU tag 1 and LSB tag 2 pushed in the same cycle after reset -> tag 1 (src 0), then tag 2 (src 1) in consecutive cycles.
REQ-038 Both sources push every cycle -> grants strictly alternate ALU/LSB, each source keeps FIFO order, ready toggles are correct, and nothing is lost or duplicated.
REQ-039 LSB pushes 3 results with no ALU traffic, DEPTH=2 -> lsb_ready=0 only while count=2; all 3 broadcast in order with pointer wrap.
REQ-040 Two entries queued per source, flush asserted -> next cycle cdb_valid=0, both readies 1, and nothing further is broadcast.
REQ-041 rst asserted while both queues hold entries and cdb_valid=1 -> all outputs at the REQ-034 values the next cycle, and the first grant after release goes to ALU.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs (ALU, LSB), round-robin grant, one broadcast per cycle.
// Latency: a result pushed at edge N is broadcast on registered cdb_* outputs in cycle N+2 at the earliest.
// Backpressure: alu_ready/lsb_ready drop only while that source FIFO is full; the producer holds its result.

`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif

module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    input  logic                     alu_valid,
    input  logic [`ROB_ID_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]              alu_value,
    input  logic [31:0]              alu_target,
    input  logic                     alu_mispredict,
    output logic                     alu_ready,

    input  logic                     lsb_valid,
    input  logic [`ROB_ID_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,
    output logic                     lsb_ready,

    output logic                     cdb_valid,
    output logic [`ROB_ID_WIDTH-1:0] cdb_rob_id,
    output logic [31:0]              cdb_value,
    output logic [31:0]              cdb_target,
    output logic                     cdb_mispredict,
    output logic                     cdb_src
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [`ROB_ID_WIDTH-1:0] rob_id;
        logic [31:0]              value;
        logic [31:0]              target;
        logic                     mispredict;
    } alu_ent_t;

    typedef struct packed {
        logic [`ROB_ID_WIDTH-1:0] rob_id;
        logic [31:0]              value;
    } lsb_ent_t;

    alu_ent_t        alu_mem [FIFO_DEPTH];
    lsb_ent_t        lsb_mem [FIFO_DEPTH];

    logic [PW-1:0]   alu_wr_ptr, alu_rd_ptr;
    logic [PW-1:0]   lsb_wr_ptr, lsb_rd_ptr;
    logic [CW-1:0]   alu_cnt, lsb_cnt;

    // 1 means LSB was granted last under contention, so ALU wins the next tie.
    logic            rr_last;

    logic            alu_push, lsb_push;
    logic            alu_ne, lsb_ne;
    logic            grant_alu, grant_lsb;
    logic            both_ne;
    alu_ent_t        alu_head;
    lsb_ent_t        lsb_head;

    // Readiness depends on occupancy alone so producers see no combinational path.
    assign alu_ready = (alu_cnt < DEPTH_C);
    assign lsb_ready = (lsb_cnt < DEPTH_C);

    assign alu_push  = alu_valid && alu_ready && !flush && !rst;
    assign lsb_push  = lsb_valid && lsb_ready && !flush && !rst;

    assign alu_ne    = (alu_cnt != '0);
    assign lsb_ne    = (lsb_cnt != '0);
    assign both_ne   = alu_ne && lsb_ne;

    assign grant_alu = alu_ne && (!lsb_ne || rr_last);
    assign grant_lsb = lsb_ne && !grant_alu;

    assign alu_head  = alu_mem[alu_rd_ptr];
    assign lsb_head  = lsb_mem[lsb_rd_ptr];

    // Storage needs no reset: occupancy is governed purely by the pointers and counts.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_mem[alu_wr_ptr] <= '{rob_id:     alu_rob_id,
                                     value:      alu_value,
                                     target:     alu_target,
                                     mispredict: alu_mispredict};
        end
        if (lsb_push) begin
            lsb_mem[lsb_wr_ptr] <= '{rob_id: lsb_rob_id,
                                     value:  lsb_value};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wr_ptr     <= '0;
            alu_rd_ptr     <= '0;
            alu_cnt        <= '0;
            lsb_wr_ptr     <= '0;
            lsb_rd_ptr     <= '0;
            lsb_cnt        <= '0;
            rr_last        <= 1'b1;
            cdb_valid      <= 1'b0;
            cdb_rob_id     <= '0;
            cdb_value      <= '0;
            cdb_target     <= '0;
            cdb_mispredict <= 1'b0;
            cdb_src        <= 1'b0;
        end else if (flush) begin
            // Mispredict recovery drops everything in flight but keeps fairness history.
            alu_wr_ptr     <= '0;
            alu_rd_ptr     <= '0;
            alu_cnt        <= '0;
            lsb_wr_ptr     <= '0;
            lsb_rd_ptr     <= '0;
            lsb_cnt        <= '0;
            cdb_valid      <= 1'b0;
        end else begin
            if (alu_push) begin
                alu_wr_ptr <= alu_wr_ptr + PW'(1);
            end
            if (lsb_push) begin
                lsb_wr_ptr <= lsb_wr_ptr + PW'(1);
            end
            if (grant_alu) begin
                alu_rd_ptr <= alu_rd_ptr + PW'(1);
            end
            if (grant_lsb) begin
                lsb_rd_ptr <= lsb_rd_ptr + PW'(1);
            end

            case ({alu_push, grant_alu})
                2'b10:   alu_cnt <= alu_cnt + CW'(1);
                2'b01:   alu_cnt <= alu_cnt - CW'(1);
                default: alu_cnt <= alu_cnt;
            endcase
            case ({lsb_push, grant_lsb})
                2'b10:   lsb_cnt <= lsb_cnt + CW'(1);
                2'b01:   lsb_cnt <= lsb_cnt - CW'(1);
                default: lsb_cnt <= lsb_cnt;
            endcase

            if (both_ne) begin
                rr_last <= grant_lsb;
            end

            if (grant_alu) begin
                cdb_valid      <= 1'b1;
                cdb_rob_id     <= alu_head.rob_id;
                cdb_value      <= alu_head.value;
                cdb_target     <= alu_head.target;
                cdb_mispredict <= alu_head.mispredict;
                cdb_src        <= 1'b0;
            end else if (grant_lsb) begin
                cdb_valid      <= 1'b1;
                cdb_rob_id     <= lsb_head.rob_id;
                cdb_value      <= lsb_head.value;
                cdb_target     <= 32'd0;
                cdb_mispredict <= 1'b0;
                cdb_src        <= 1'b1;
            end else begin
                cdb_valid      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter with a queue-based reference model plus directed scenarios.

`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif

module tb_cdb_arbiter;

    localparam int D  = 2;
    localparam int RW = `ROB_ID_WIDTH;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          alu_valid, alu_mispredict, alu_ready;
    logic [RW-1:0] alu_rob_id;
    logic [31:0]   alu_value, alu_target;
    logic          lsb_valid, lsb_ready;
    logic [RW-1:0] lsb_rob_id;
    logic [31:0]   lsb_value;
    logic          cdb_valid, cdb_mispredict, cdb_src;
    logic [RW-1:0] cdb_rob_id;
    logic [31:0]   cdb_value, cdb_target;

    cdb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .alu_target(alu_target), .alu_mispredict(alu_mispredict), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .cdb_target(cdb_target), .cdb_mispredict(cdb_mispredict), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] id;
        logic [31:0]   v;
        logic [31:0]   t;
        logic          m;
    } ent_t;

    ent_t          aq[$];
    ent_t          lq[$];
    bit            m_alu_pref;
    bit            m_known;
    logic          m_v, m_m, m_src;
    logic [RW-1:0] m_id;
    logic [31:0]   m_val, m_t;
    bit            acc_a, acc_l;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, from the inputs currently applied.
    task automatic model_edge();
        bit   an, ln;
        ent_t e;
        an = (aq.size() > 0);
        ln = (lq.size() > 0);
        acc_a = 0;
        acc_l = 0;
        if (rst) begin
            aq.delete(); lq.delete();
            m_alu_pref = 1;
            m_v = 0; m_id = '0; m_val = '0; m_t = '0; m_m = 0; m_src = 0;
            m_known = 1;
        end else if (flush) begin
            aq.delete(); lq.delete();
            m_v = 0;
            m_known = 0;
        end else begin
            acc_a = alu_valid && (aq.size() < D);
            acc_l = lsb_valid && (lq.size() < D);
            if (an && (!ln || m_alu_pref)) begin
                e = aq.pop_front();
                m_v = 1; m_id = e.id; m_val = e.v; m_t = e.t; m_m = e.m; m_src = 0;
                if (ln) m_alu_pref = 0;
                m_known = 1;
            end else if (ln) begin
                e = lq.pop_front();
                m_v = 1; m_id = e.id; m_val = e.v; m_t = 32'd0; m_m = 0; m_src = 1;
                if (an) m_alu_pref = 1;
                m_known = 1;
            end else begin
                m_v = 0;
            end
            if (acc_a) aq.push_back('{id: alu_rob_id, v: alu_value, t: alu_target, m: alu_mispredict});
            if (acc_l) lq.push_back('{id: lsb_rob_id, v: lsb_value, t: 32'd0, m: 1'b0});
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_v});
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, (aq.size() < D)});
        chk("lsb_ready", {63'd0, lsb_ready}, {63'd0, (lq.size() < D)});
        if (m_known) begin
            chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_id));
            chk("cdb_value", 64'(cdb_value), 64'(m_val));
            chk("cdb_target", 64'(cdb_target), 64'(m_t));
            chk("cdb_misp", {63'd0, cdb_mispredict}, {63'd0, m_m});
            chk("cdb_src", {63'd0, cdb_src}, {63'd0, m_src});
        end
    endtask

    task automatic idle();
        alu_valid = 0; lsb_valid = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic push_both(input logic [RW-1:0] ta, input logic [RW-1:0] tl);
        alu_valid = 1; alu_rob_id = ta; alu_value = 32'hA000 + 32'(ta);
        alu_target = 32'h400 + 32'(ta); alu_mispredict = ta[0];
        lsb_valid = 1; lsb_rob_id = tl; lsb_value = 32'hB000 + 32'(tl);
    endtask

    initial begin
        rst = 1; flush = 0;
        alu_valid = 0; alu_rob_id = '0; alu_value = '0; alu_target = '0; alu_mispredict = 0;
        lsb_valid = 0; lsb_rob_id = '0; lsb_value = '0;

        do_reset();
        chk("rst_valid", {63'd0, cdb_valid}, 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        step();
        chk("post_rst_alu_rdy", {63'd0, alu_ready}, 64'd1);
        chk("post_rst_lsb_rdy", {63'd0, lsb_ready}, 64'd1);

        // Single ALU result with all fields distinct.
        alu_valid = 1; alu_rob_id = RW'(3); alu_value = 32'h55;
        alu_target = 32'h100; alu_mispredict = 1;
        step();
        idle();
        step();
        chk("single_valid", {63'd0, cdb_valid}, 64'd1);
        chk("single_src", {63'd0, cdb_src}, 64'd0);
        chk("single_tag", 64'(cdb_rob_id), 64'd3);
        chk("single_value", 64'(cdb_value), 64'h55);
        chk("single_target", 64'(cdb_target), 64'h100);
        chk("single_misp", {63'd0, cdb_mispredict}, 64'd1);
        step();
        chk("single_drop", {63'd0, cdb_valid}, 64'd0);

        // Same-cycle pushes from both sources right after reset.
        do_reset();
        push_both(RW'(1), RW'(2));
        step();
        idle();
        step();
        chk("pair_first_tag", 64'(cdb_rob_id), 64'd1);
        chk("pair_first_src", {63'd0, cdb_src}, 64'd0);
        step();
        chk("pair_second_tag", 64'(cdb_rob_id), 64'd2);
        chk("pair_second_src", {63'd0, cdb_src}, 64'd1);
        step();

        // Both sources backlogged: producers hold on ready=0, grants alternate.
        begin
            logic [RW-1:0] ta, tl;
            logic          prev_src;
            ta = '0; tl = RW'(8);
            push_both(ta, tl);
            step();
            for (int i = 0; i < 40; i++) begin
                if (acc_a) ta = ta + RW'(1);
                if (acc_l) tl = tl + RW'(1);
                push_both(ta, tl);
                prev_src = cdb_src;
                step();
                if (i > 4) chk("alternate", {63'd0, cdb_src}, {63'd0, ~prev_src});
            end
            idle();
            for (int i = 0; i < 6; i++) step();
        end

        // LSB-only burst of three, exercising pointer wrap.
        begin
            logic [RW-1:0] tl;
            int            sent;
            tl = RW'(5); sent = 0;
            for (int i = 0; i < 20 && sent < 3; i++) begin
                lsb_valid = 1; lsb_rob_id = tl; lsb_value = 32'hC0 + 32'(tl);
                step();
                if (acc_l) begin tl = tl + RW'(1); sent++; end
            end
            chk("lsb_burst_sent", 64'(sent), 64'd3);
            idle();
            for (int i = 0; i < 4; i++) step();
        end

        // Fill both queues, then flush.
        for (int i = 0; i < 4; i++) begin
            push_both(RW'(i), RW'(i + 4));
            step();
        end
        idle();
        flush = 1;
        step();
        flush = 0;
        chk("flush_valid", {63'd0, cdb_valid}, 64'd0);
        chk("flush_alu_rdy", {63'd0, alu_ready}, 64'd1);
        chk("flush_lsb_rdy", {63'd0, lsb_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_quiet", {63'd0, cdb_valid}, 64'd0);
        end

        // Reset while busy, then first contended grant goes to ALU.
        for (int i = 0; i < 4; i++) begin
            push_both(RW'(i + 2), RW'(i + 9));
            step();
        end
        idle();
        rst = 1;
        step();
        chk("busy_rst_valid", {63'd0, cdb_valid}, 64'd0);
        chk("busy_rst_tag", 64'(cdb_rob_id), 64'd0);
        chk("busy_rst_target", 64'(cdb_target), 64'd0);
        chk("busy_rst_src", {63'd0, cdb_src}, 64'd0);
        rst = 0;
        push_both(RW'(12), RW'(13));
        step();
        idle();
        step();
        chk("rst_first_grant_src", {63'd0, cdb_src}, 64'd0);
        chk("rst_first_grant_tag", 64'(cdb_rob_id), 64'd12);
        step();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            if (!(alu_valid && !acc_a)) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rob_id = RW'($urandom);
                alu_value = $urandom;
                alu_target = $urandom;
                alu_mispredict = 1'($urandom);
            end
            if (!(lsb_valid && !acc_l)) begin
                lsb_valid = ($urandom_range(0, 2) != 0);
                lsb_rob_id = RW'($urandom);
                lsb_value = $urandom;
            end
            flush = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
